// File: rtl/eth_rx_hdr_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_hdr_parser_if
// Brief    : Byte-wide Avalon-ST style frame stream (sop/eop/valid/data/error)
// Revision : 1.0 - initial release
// ============================================================================
interface eth_rx_hdr_parser_if;
    logic       startofpacket;
    logic       endofpacket;
    logic       valid;
    logic [7:0] data;
    logic       error;

    modport master (output startofpacket, endofpacket, valid, data, error);
    modport slave  (input  startofpacket, endofpacket, valid, data, error);
endinterface
`default_nettype wire

// File: rtl/eth_rx_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_hdr_parser
// Brief    : Ethernet header extraction, dst-address filter, payload forwarding
//            and saturating frame statistics
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_hdr_parser #(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC  = 1'b0,
    parameter int          CNT_W    = 16
) (
    input  wire logic               mac_clk,
    input  wire logic               rst,
    eth_rx_hdr_parser_if.slave      in_if,
    eth_rx_hdr_parser_if.master     out_if,
    output logic                    hdr_valid,
    output logic [47:0]             hdr_dst_mac,
    output logic [47:0]             hdr_src_mac,
    output logic [15:0]             hdr_ethertype,
    output logic [CNT_W-1:0]        cnt_ok,
    output logic [CNT_W-1:0]        cnt_err,
    output logic [CNT_W-1:0]        cnt_drop,
    output logic [CNT_W-1:0]        cnt_runt
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_hdr     = 2'd1;
    localparam logic [1:0] c_payload = 2'd2;
    localparam logic [1:0] c_drop    = 2'd3;

    logic [1:0]       r_state;
    logic [3:0]       r_idx;
    logic [103:0]     r_sh;
    logic             r_accept;
    logic             r_first;

    logic             r_out_valid;
    logic             r_out_sop;
    logic             r_out_eop;
    logic             r_out_err;
    logic [7:0]       r_out_data;
    logic             r_hdr_valid;
    logic [47:0]      r_dst;
    logic [47:0]      r_src;
    logic [15:0]      r_type;
    logic [CNT_W-1:0] r_cnt_ok;
    logic [CNT_W-1:0] r_cnt_err;
    logic [CNT_W-1:0] r_cnt_drop;
    logic [CNT_W-1:0] r_cnt_runt;

    logic [1:0]       w_state_nxt;
    logic [3:0]       w_idx_nxt;
    logic             w_accept_nxt;
    logic             w_first_nxt;
    logic             w_fwd;
    logic             w_abort;
    logic             w_hdr_load;
    logic             w_inc_ok;
    logic             w_inc_err;
    logic             w_inc_drop;
    logic             w_inc_runt;
    logic [47:0]      w_dst;
    logic             w_dst_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // Bytes 0..4 already sit in the low end of the shift register when byte 5 arrives.
    assign w_dst     = {r_sh[39:0], in_if.data};
    assign w_dst_hit = PROMISC || (w_dst == MAC_ADDR) || (w_dst == {48{1'b1}});

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_accept_nxt = r_accept;
        w_first_nxt  = r_first;
        w_fwd        = 1'b0;
        w_abort      = 1'b0;
        w_hdr_load   = 1'b0;
        w_inc_ok     = 1'b0;
        w_inc_err    = 1'b0;
        w_inc_drop   = 1'b0;
        w_inc_runt   = 1'b0;
        if (in_if.valid) begin
            if (in_if.startofpacket) begin
                w_abort   = (r_state == c_payload);
                w_idx_nxt = 4'd1;
                if (in_if.endofpacket) begin
                    w_inc_runt  = 1'b1;
                    w_state_nxt = c_idle;
                end else begin
                    w_state_nxt = c_hdr;
                end
            end else begin
                case (r_state)
                    c_hdr: begin
                        if (r_idx == 4'd5) begin
                            w_accept_nxt = w_dst_hit;
                        end
                        if (in_if.endofpacket) begin
                            w_inc_runt  = 1'b1;
                            w_state_nxt = c_idle;
                        end else if (r_idx == 4'd13) begin
                            if (r_accept) begin
                                w_state_nxt = c_payload;
                                w_hdr_load  = 1'b1;
                                w_first_nxt = 1'b1;
                            end else begin
                                w_state_nxt = c_drop;
                                w_inc_drop  = 1'b1;
                            end
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                    c_payload: begin
                        w_fwd       = 1'b1;
                        w_first_nxt = 1'b0;
                        if (in_if.endofpacket) begin
                            w_state_nxt = c_idle;
                            w_inc_err   = in_if.error;
                            w_inc_ok    = ~in_if.error;
                        end
                    end
                    c_drop: begin
                        if (in_if.endofpacket) begin
                            w_state_nxt = c_idle;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge mac_clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_idx       <= 4'd0;
            r_sh        <= '0;
            r_accept    <= 1'b0;
            r_first     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= 8'h00;
            r_hdr_valid <= 1'b0;
            r_dst       <= '0;
            r_src       <= '0;
            r_type      <= '0;
            r_cnt_ok    <= '0;
            r_cnt_err   <= '0;
            r_cnt_drop  <= '0;
            r_cnt_runt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_accept <= w_accept_nxt;
            r_first  <= w_first_nxt;
            if (in_if.valid) begin
                r_sh <= {r_sh[95:0], in_if.data};
            end
            // An abort beat and a forwarded beat are mutually exclusive: a sop never forwards.
            r_out_valid <= w_fwd | w_abort;
            r_out_sop   <= w_fwd & r_first;
            r_out_eop   <= w_abort | (w_fwd & in_if.endofpacket);
            r_out_err   <= w_abort | (w_fwd & in_if.endofpacket & in_if.error);
            r_out_data  <= w_fwd ? in_if.data : 8'h00;
            r_hdr_valid <= w_hdr_load;
            if (w_hdr_load) begin
                r_dst  <= r_sh[103:56];
                r_src  <= r_sh[55:8];
                r_type <= {r_sh[7:0], in_if.data};
            end
            r_cnt_ok   <= sat_inc(r_cnt_ok,   w_inc_ok);
            r_cnt_err  <= sat_inc(r_cnt_err,  w_inc_err | w_abort);
            r_cnt_drop <= sat_inc(r_cnt_drop, w_inc_drop);
            r_cnt_runt <= sat_inc(r_cnt_runt, w_inc_runt);
        end
    end

    assign out_if.valid         = r_out_valid;
    assign out_if.startofpacket = r_out_sop;
    assign out_if.endofpacket   = r_out_eop;
    assign out_if.error         = r_out_err;
    assign out_if.data          = r_out_data;
    assign hdr_valid            = r_hdr_valid;
    assign hdr_dst_mac          = r_dst;
    assign hdr_src_mac          = r_src;
    assign hdr_ethertype        = r_type;
    assign cnt_ok               = r_cnt_ok;
    assign cnt_err              = r_cnt_err;
    assign cnt_drop             = r_cnt_drop;
    assign cnt_runt             = r_cnt_runt;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_hdr_parser
// Brief    : Self-checking bench: frame-level reference model vs three DUT configs
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_hdr_parser;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;

    typedef struct {
        logic       sop;
        logic       eop;
        logic       err;
        logic [7:0] data;
        int         stamp;
    } beat_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        int          stamp;
    } hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    eth_rx_hdr_parser_if in_if ();
    eth_rx_hdr_parser_if out0 ();
    eth_rx_hdr_parser_if out1 ();
    eth_rx_hdr_parser_if out2 ();

    logic        hv0, hv1, hv2;
    logic [47:0] d0, s0, d1, s1, d2, s2;
    logic [15:0] t0, t1, t2;
    logic [15:0] ok0, err0, drop0, runt0;
    logic [15:0] ok1, err1, drop1, runt1;
    logic [1:0]  ok2, err2, drop2, runt2;

    eth_rx_hdr_parser #(.MAC_ADDR(MAC), .PROMISC(1'b0), .CNT_W(16)) dut0 (
        .mac_clk(clk), .rst(rst), .in_if(in_if), .out_if(out0),
        .hdr_valid(hv0), .hdr_dst_mac(d0), .hdr_src_mac(s0), .hdr_ethertype(t0),
        .cnt_ok(ok0), .cnt_err(err0), .cnt_drop(drop0), .cnt_runt(runt0));

    eth_rx_hdr_parser #(.MAC_ADDR(MAC), .PROMISC(1'b1), .CNT_W(16)) dut1 (
        .mac_clk(clk), .rst(rst), .in_if(in_if), .out_if(out1),
        .hdr_valid(hv1), .hdr_dst_mac(d1), .hdr_src_mac(s1), .hdr_ethertype(t1),
        .cnt_ok(ok1), .cnt_err(err1), .cnt_drop(drop1), .cnt_runt(runt1));

    eth_rx_hdr_parser #(.MAC_ADDR(MAC), .PROMISC(1'b0), .CNT_W(2)) dut2 (
        .mac_clk(clk), .rst(rst), .in_if(in_if), .out_if(out2),
        .hdr_valid(hv2), .hdr_dst_mac(d2), .hdr_src_mac(s2), .hdr_ethertype(t2),
        .cnt_ok(ok2), .cnt_err(err2), .cnt_drop(drop2), .cnt_runt(runt2));

    int total = 0;
    int bad   = 0;

    // Model state: index 0 = filtering config, index 1 = promiscuous config.
    beat_t exp0_q[$], exp1_q[$], act0_q[$], act1_q[$];
    hdr_t  exph_q[$], acth_q[$];
    int    e_ok[2], e_err[2], e_drop[2], e_runt[2];
    bit    pend[2];

    int   ncyc = 0;
    int   side_bad = 0;
    logic rst_prev = 1'b0;
    bit   snap_nz = 1'b1;

    always @(posedge clk) rst_prev <= rst;

    always @(negedge clk) begin
        beat_t b;
        hdr_t  h;
        ncyc++;
        if (out0.valid) begin
            b.sop = out0.startofpacket; b.eop = out0.endofpacket; b.err = out0.error;
            b.data = out0.data; b.stamp = ncyc;
            act0_q.push_back(b);
        end
        if (out1.valid) begin
            b.sop = out1.startofpacket; b.eop = out1.endofpacket; b.err = out1.error;
            b.data = out1.data; b.stamp = ncyc;
            act1_q.push_back(b);
        end
        if ((!out0.valid && (out0.startofpacket || out0.endofpacket || out0.error)) ||
            (!out1.valid && (out1.startofpacket || out1.endofpacket || out1.error)))
            side_bad++;
        if (hv0) begin
            h.dst = d0; h.src = s0; h.et = t0; h.stamp = ncyc;
            acth_q.push_back(h);
        end
        if (rst_prev)
            snap_nz = |{out0.valid, out0.startofpacket, out0.endofpacket, out0.error, out0.data,
                        hv0, d0, s0, t0, ok0, err0, drop0, runt0};
    end

    function automatic int beat_diffs(input beat_t e[$], input beat_t a[$]);
        int n = (e.size() > a.size()) ? e.size() - a.size() : a.size() - e.size();
        int m = (e.size() < a.size()) ? e.size() : a.size();
        for (int i = 0; i < m; i++)
            if (e[i].sop !== a[i].sop || e[i].eop !== a[i].eop || e[i].err !== a[i].err ||
                e[i].data !== a[i].data || e[i].stamp != a[i].stamp)
                n++;
        return n;
    endfunction

    function automatic int hdr_diffs(input hdr_t e[$], input hdr_t a[$]);
        int n = (e.size() > a.size()) ? e.size() - a.size() : a.size() - e.size();
        int m = (e.size() < a.size()) ? e.size() : a.size();
        for (int i = 0; i < m; i++)
            if (e[i].dst !== a[i].dst || e[i].src !== a[i].src || e[i].et !== a[i].et ||
                e[i].stamp != a[i].stamp)
                n++;
        return n;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic clear_q();
        exp0_q.delete(); exp1_q.delete(); act0_q.delete(); act1_q.delete();
        exph_q.delete(); acth_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            in_if.valid = 1'b0; in_if.startofpacket = 1'b0; in_if.endofpacket = 1'b0;
            in_if.error = 1'b0; in_if.data = 8'h00; rst = 1'b0;
        end
    endtask

    // Drives one frame with random idle gaps, then applies the frame-level rules to the model.
    task automatic drive_frame(input int len, input logic [47:0] dst, input logic [15:0] et,
                               input bit ferr, input bit has_eop, input int rst_at,
                               input int gap_pct);
        logic [7:0]  fb[$];
        int          st[$];
        logic [63:0] r64;
        logic [47:0] src;
        beat_t       b;
        hdr_t        h;
        bit          acc, complete;
        int          t_len;
        r64 = {$urandom(), $urandom()};
        src = r64[47:0];
        for (int i = 0; i < len; i++) begin
            if (i < 6)        fb.push_back(dst[47-8*i -: 8]);
            else if (i < 12)  fb.push_back(src[47-8*(i-6) -: 8]);
            else if (i == 12) fb.push_back(et[15:8]);
            else if (i == 13) fb.push_back(et[7:0]);
            else              fb.push_back(8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < len; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                @(negedge clk); #1;
                in_if.valid = 1'b0; in_if.startofpacket = 1'($urandom());
                in_if.endofpacket = 1'($urandom()); in_if.error = 1'($urandom());
                in_if.data = 8'($urandom()); rst = 1'b0;
            end
            @(negedge clk); #1;
            rst = (i == rst_at);
            in_if.valid = 1'b1;
            in_if.startofpacket = (i == 0);
            in_if.endofpacket = has_eop && (i == len - 1);
            in_if.error = (has_eop && (i == len - 1)) ? ferr : 1'($urandom());
            in_if.data = fb[i];
            st.push_back(ncyc);
        end

        t_len    = (rst_at >= 0) ? rst_at : len;
        complete = has_eop && (rst_at < 0);
        for (int p = 0; p < 2; p++) begin
            acc = (p == 1) || (dst == MAC) || (dst == BCAST);
            if (pend[p]) begin
                b.sop = 1'b0; b.eop = 1'b1; b.err = 1'b1; b.data = 8'h00; b.stamp = st[0] + 1;
                if (p == 0) exp0_q.push_back(b); else exp1_q.push_back(b);
                e_err[p]++;
                pend[p] = 1'b0;
            end
            if (complete && t_len <= 14) begin
                e_runt[p]++;
            end else if (t_len >= 14) begin
                if (!acc) begin
                    e_drop[p]++;
                end else begin
                    if (p == 0) begin
                        h.dst = dst; h.src = src; h.et = et; h.stamp = st[13] + 1;
                        exph_q.push_back(h);
                    end
                    for (int i = 14; i < t_len; i++) begin
                        b.sop = (i == 14);
                        b.eop = complete && (i == t_len - 1);
                        b.err = complete && (i == t_len - 1) && ferr;
                        b.data = fb[i];
                        b.stamp = st[i] + 1;
                        if (p == 0) exp0_q.push_back(b); else exp1_q.push_back(b);
                    end
                    if (complete) begin
                        if (ferr) e_err[p]++; else e_ok[p]++;
                    end else if (rst_at < 0) begin
                        pend[p] = 1'b1;
                    end
                end
            end
        end
        if (rst_at >= 0) begin
            for (int p = 0; p < 2; p++) begin
                e_ok[p] = 0; e_err[p] = 0; e_drop[p] = 0; e_runt[p] = 0; pend[p] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if (|{out0.valid, out0.startofpacket, out0.endofpacket, out0.error, out0.data,
              hv0, d0, s0, t0} !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b hdr_valid=%b dst=%h want all zero",
                     out0.valid, hv0, d0);
        end
        total++;
        if ({ok0, err0, drop0, runt0, ok2, err2, drop2, runt2} !== 72'd0) begin
            bad++;
            $display("FAIL reset_counters got ok=%0d err=%0d drop=%0d runt=%0d want 0",
                     ok0, err0, drop0, runt0);
        end
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        int d;
        drive_frame(64, MAC, 16'h0800, 1'b0, 1'b1, -1, 0);
        idle(4);
        d = hdr_diffs(exph_q, acth_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL good_hdr diffs=%0d got_pulses=%0d want_pulses=%0d", d, acth_q.size(), exph_q.size());
        end
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0 || act0_q.size() !== 50) begin
            bad++;
            $display("FAIL good_payload diffs=%0d got_beats=%0d want_beats=50", d, act0_q.size());
        end
        total++;
        if (ok0 !== 16'(e_ok[0]) || err0 !== 16'(e_err[0])) begin
            bad++;
            $display("FAIL good_cnt got ok=%0d err=%0d want ok=%0d err=%0d", ok0, err0, e_ok[0], e_err[0]);
        end
        clear_q();
    endtask

    task automatic test_filter();
        int d;
        drive_frame(64, BCAST, 16'h0806, 1'b0, 1'b1, -1, 20);
        drive_frame(64, OTHER, 16'h0800, 1'b0, 1'b1, -1, 20);
        idle(4);
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0 || act0_q.size() !== 50) begin
            bad++;
            $display("FAIL filter_payload diffs=%0d got_beats=%0d want_beats=50", d, act0_q.size());
        end
        total++;
        if (drop0 !== 16'(e_drop[0]) || ok0 !== 16'(e_ok[0])) begin
            bad++;
            $display("FAIL filter_cnt got drop=%0d ok=%0d want drop=%0d ok=%0d", drop0, ok0, e_drop[0], e_ok[0]);
        end
        d = beat_diffs(exp1_q, act1_q);
        total++;
        if (d !== 0 || act1_q.size() !== 100) begin
            bad++;
            $display("FAIL promisc_payload diffs=%0d got_beats=%0d want_beats=100", d, act1_q.size());
        end
        total++;
        if (drop1 !== 16'(e_drop[1]) || ok1 !== 16'(e_ok[1])) begin
            bad++;
            $display("FAIL promisc_cnt got drop=%0d ok=%0d want drop=%0d ok=%0d", drop1, ok1, e_drop[1], e_ok[1]);
        end
        clear_q();
    endtask

    task automatic test_error_runt();
        int d;
        drive_frame(60, MAC, 16'h0800, 1'b1, 1'b1, -1, 10);
        drive_frame(10, MAC, 16'h0800, 1'b0, 1'b1, -1, 10);
        drive_frame(14, MAC, 16'h0800, 1'b0, 1'b1, -1, 10);
        drive_frame(1,  MAC, 16'h0800, 1'b0, 1'b1, -1, 10);
        drive_frame(12, OTHER, 16'h0800, 1'b0, 1'b1, -1, 10);
        drive_frame(15, MAC, 16'h86DD, 1'b0, 1'b1, -1, 10);
        idle(4);
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL err_payload diffs=%0d got_beats=%0d want_beats=%0d", d, act0_q.size(), exp0_q.size());
        end
        d = hdr_diffs(exph_q, acth_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL runt_hdr diffs=%0d got_pulses=%0d want_pulses=%0d", d, acth_q.size(), exph_q.size());
        end
        total++;
        if (err0 !== 16'(e_err[0]) || runt0 !== 16'(e_runt[0]) || drop0 !== 16'(e_drop[0]) ||
            ok0 !== 16'(e_ok[0])) begin
            bad++;
            $display("FAIL err_runt_cnt got err=%0d runt=%0d drop=%0d ok=%0d want %0d %0d %0d %0d",
                     err0, runt0, drop0, ok0, e_err[0], e_runt[0], e_drop[0], e_ok[0]);
        end
        clear_q();
    endtask

    task automatic test_abort();
        int d;
        drive_frame(30, MAC, 16'h0800, 1'b0, 1'b0, -1, 10);
        drive_frame(64, MAC, 16'h0800, 1'b0, 1'b1, -1, 10);
        idle(4);
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL abort_payload diffs=%0d got_beats=%0d want_beats=%0d", d, act0_q.size(), exp0_q.size());
        end
        total++;
        if (err0 !== 16'(e_err[0]) || ok0 !== 16'(e_ok[0])) begin
            bad++;
            $display("FAIL abort_cnt got err=%0d ok=%0d want err=%0d ok=%0d", err0, ok0, e_err[0], e_ok[0]);
        end
        d = hdr_diffs(exph_q, acth_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL abort_hdr diffs=%0d got_pulses=%0d want_pulses=%0d", d, acth_q.size(), exph_q.size());
        end
        clear_q();
    endtask

    task automatic test_mid_reset();
        int d;
        snap_nz = 1'b1;
        drive_frame(64, MAC, 16'h0800, 1'b0, 1'b1, 20, 0);
        idle(4);
        total++;
        if (snap_nz !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs got nonzero=%b want 0", snap_nz);
        end
        total++;
        if ({ok0, err0, drop0, runt0, ok2, err2, drop2, runt2} !== 72'd0) begin
            bad++;
            $display("FAIL midrst_counters got ok=%0d err=%0d drop=%0d runt=%0d want 0", ok0, err0, drop0, runt0);
        end
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL midrst_payload diffs=%0d got_beats=%0d want_beats=%0d", d, act0_q.size(), exp0_q.size());
        end
        clear_q();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++)
            drive_frame(int'($urandom_range(15, 80)), MAC, 16'h0800, 1'b0, 1'b1, -1, 30);
        idle(4);
        total++;
        if (ok2 !== 2'(sat3(e_ok[0])) || ok2 !== 2'd3) begin
            bad++;
            $display("FAIL sat_cnt_ok got=%0d want=3", ok2);
        end
        total++;
        if (ok0 !== 16'(e_ok[0])) begin
            bad++;
            $display("FAIL wide_cnt_ok got=%0d want=%0d", ok0, e_ok[0]);
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int d;
        drive_frame(20, MAC,   16'h0800, 1'b0, 1'b1, -1, 0);
        drive_frame(20, BCAST, 16'h0800, 1'b1, 1'b1, -1, 0);
        drive_frame(15, MAC,   16'h0800, 1'b0, 1'b1, -1, 0);
        idle(4);
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL b2b_payload diffs=%0d got_beats=%0d want_beats=%0d", d, act0_q.size(), exp0_q.size());
        end
        d = hdr_diffs(exph_q, acth_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL b2b_hdr diffs=%0d got_pulses=%0d want_pulses=%0d", d, acth_q.size(), exph_q.size());
        end
        clear_q();
    endtask

    task automatic test_random();
        int          d;
        logic [63:0] r64;
        logic [47:0] dst;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: dst = MAC;
                1: dst = BCAST;
                2: dst = OTHER;
                default: begin r64 = {$urandom(), $urandom()}; dst = r64[47:0]; end
            endcase
            drive_frame(int'($urandom_range(1, 90)), dst, 16'($urandom()), 1'($urandom()),
                        (i == 23) || ($urandom_range(0, 9) != 0), -1, int'($urandom_range(0, 40)));
        end
        idle(4);
        d = beat_diffs(exp0_q, act0_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL rand_payload diffs=%0d got_beats=%0d want_beats=%0d", d, act0_q.size(), exp0_q.size());
        end
        d = beat_diffs(exp1_q, act1_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL rand_promisc_payload diffs=%0d got_beats=%0d want_beats=%0d", d, act1_q.size(), exp1_q.size());
        end
        d = hdr_diffs(exph_q, acth_q);
        total++;
        if (d !== 0) begin
            bad++;
            $display("FAIL rand_hdr diffs=%0d got_pulses=%0d want_pulses=%0d", d, acth_q.size(), exph_q.size());
        end
        total++;
        if (ok0 !== 16'(e_ok[0]) || err0 !== 16'(e_err[0]) || drop0 !== 16'(e_drop[0]) ||
            runt0 !== 16'(e_runt[0])) begin
            bad++;
            $display("FAIL rand_cnt got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", ok0, err0, drop0, runt0,
                     e_ok[0], e_err[0], e_drop[0], e_runt[0]);
        end
        total++;
        if (ok1 !== 16'(e_ok[1]) || err1 !== 16'(e_err[1]) || drop1 !== 16'(e_drop[1]) ||
            runt1 !== 16'(e_runt[1])) begin
            bad++;
            $display("FAIL rand_promisc_cnt got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", ok1, err1, drop1, runt1,
                     e_ok[1], e_err[1], e_drop[1], e_runt[1]);
        end
        total++;
        if (ok2 !== 2'(sat3(e_ok[0])) || err2 !== 2'(sat3(e_err[0])) ||
            drop2 !== 2'(sat3(e_drop[0])) || runt2 !== 2'(sat3(e_runt[0]))) begin
            bad++;
            $display("FAIL rand_sat_cnt got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", ok2, err2, drop2, runt2,
                     sat3(e_ok[0]), sat3(e_err[0]), sat3(e_drop[0]), sat3(e_runt[0]));
        end
        total++;
        if (side_bad !== 0) begin
            bad++;
            $display("FAIL sideband_idle got=%0d want=0", side_bad);
        end
        clear_q();
    endtask

    initial begin
        in_if.valid = 1'b0; in_if.startofpacket = 1'b0; in_if.endofpacket = 1'b0;
        in_if.error = 1'b0; in_if.data = 8'h00;
        for (int p = 0; p < 2; p++) begin
            e_ok[p] = 0; e_err[p] = 0; e_drop[p] = 0; e_runt[p] = 0; pend[p] = 1'b0;
        end
        test_reset();
        clear_q();
        test_good_frame();
        test_filter();
        test_error_runt();
        test_abort();
        test_mid_reset();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
